// File: rtl/uart_proto_pkg.sv
// Shared definitions for the game-state UART link: word tags, field widths,
// scheduler state encoding and the per-frame snapshot record.
// Build option: UART_FRAME_CHECKSUM_EN appends a checksum word to every frame.
package uart_proto_pkg;

  localparam int TAG_W     = 4;
  localparam int PAYLOAD_W = 12;
  localparam int WORD_W    = TAG_W + PAYLOAD_W;

  localparam logic [TAG_W-1:0] TAG_MATCH_CTRL = 4'h0;
  localparam logic [TAG_W-1:0] TAG_PL1_POSX   = 4'h3;
  localparam logic [TAG_W-1:0] TAG_PL1_POSY   = 4'h4;
  localparam logic [TAG_W-1:0] TAG_BALL_POSX  = 4'h5;
  localparam logic [TAG_W-1:0] TAG_BALL_POSY  = 4'h6;
  localparam logic [TAG_W-1:0] TAG_CSUM       = 4'hF;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] SLOT_LAST = 3'd5;
`else
  localparam logic [2:0] SLOT_LAST = 3'd4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                 snap_end;
    logic                 snap_point;
    logic [3:0]           pl2_score;
    logic [3:0]           pl1_score;
    logic [PAYLOAD_W-1:0] pl1_posx;
    logic [PAYLOAD_W-1:0] pl1_posy;
    logic [PAYLOAD_W-1:0] ball_posx;
    logic [PAYLOAD_W-1:0] ball_posy;
  } frame_snap_t;

endpackage

// File: rtl/uart_frame_sched_if.sv
// Tagged 16-bit word handshake between the frame scheduler and the 16-to-8
// converter. A word moves on word_valid & word_ready.
interface uart_frame_sched_if;
  import uart_proto_pkg::*;

  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/uart_slot_sel.sv
// Maps a slot index onto its {tag, payload} word using the frozen frame
// snapshot. Slot 5 (checksum) exists only with UART_FRAME_CHECKSUM_EN.
module uart_slot_sel
  import uart_proto_pkg::*;
(
  input  frame_snap_t       snap,
  input  logic [2:0]        slot,
  output logic [WORD_W-1:0] word
);

  logic [PAYLOAD_W-1:0] ctrl_payload;

  assign ctrl_payload = {2'b00, snap.snap_end, snap.snap_point, snap.pl2_score, snap.pl1_score};

  // Slot decode; unused indices yield zero.
  always_comb begin
    word = '0;
    case (slot)
      3'd0: word = {TAG_MATCH_CTRL, ctrl_payload};
      3'd1: word = {TAG_PL1_POSX, snap.pl1_posx};
      3'd2: word = {TAG_PL1_POSY, snap.pl1_posy};
      3'd3: word = {TAG_BALL_POSX, snap.ball_posx};
      3'd4: word = {TAG_BALL_POSY, snap.ball_posy};
`ifdef UART_FRAME_CHECKSUM_EN
      3'd5: word = {TAG_CSUM, ctrl_payload ^ snap.pl1_posx ^ snap.pl1_posy
                              ^ snap.ball_posx ^ snap.ball_posy};
`endif
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Per-frame scheduler for the game-state UART link. A frame_tick snapshots
// the game state and the frame's words are then issued in fixed slot order,
// followed by an enforced idle gap. Ticks arriving while busy are counted.
// Build option: UART_FRAME_CHECKSUM_EN (adds checksum slot 5).
//
// state   | meaning
// IDLE    | waiting for frame_tick
// SEND    | presenting slot words 0..SLOT_LAST
// GAP     | MIN_GAP-cycle down-counter before the next tick is accepted
module uart_frame_sched
  import uart_proto_pkg::*;
#(
  parameter int MIN_GAP    = 16,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [PAYLOAD_W-1:0]  pl1_posx,
  input  logic [PAYLOAD_W-1:0]  pl1_posy,
  input  logic [PAYLOAD_W-1:0]  ball_posx,
  input  logic [PAYLOAD_W-1:0]  ball_posy,
  input  logic [3:0]            pl1_score,
  input  logic [3:0]            pl2_score,
  input  logic                  flag_point,
  input  logic                  end_game,
  uart_frame_sched_if.master    word_if,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  sched_state_t      state;
  logic [2:0]        slot;
  logic [GAP_W-1:0]  gap_cnt;
  logic              pend_point;
  logic              pend_end;
  logic              accept;
  frame_snap_t       snap;
  logic [WORD_W-1:0] sel_word;

  assign accept = (state == ST_IDLE) && frame_tick;

  uart_slot_sel u_slot_sel (
    .snap (snap),
    .slot (slot),
    .word (sel_word)
  );

  // Words come straight from registered snapshot and slot, so they hold
  // steady under backpressure; zero whenever nothing is offered.
  assign word_if.word_data = word_if.word_valid ? sel_word : '0;

  // Frame FSM, snapshot capture, event latching and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      slot               <= '0;
      gap_cnt            <= '0;
      word_if.word_valid <= 1'b0;
      busy               <= 1'b0;
      drop_cnt           <= '0;
      pend_point         <= 1'b0;
      pend_end           <= 1'b0;
      snap               <= '0;
    end else begin
      // Events on the accept edge go into this frame, so pending clears.
      if (accept) begin
        pend_point <= 1'b0;
        pend_end   <= 1'b0;
      end else begin
        pend_point <= pend_point | flag_point;
        pend_end   <= pend_end | end_game;
      end

      if (frame_tick && (state != ST_IDLE) && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            snap.snap_end      <= pend_end | end_game;
            snap.snap_point    <= pend_point | flag_point;
            snap.pl2_score     <= pl2_score;
            snap.pl1_score     <= pl1_score;
            snap.pl1_posx      <= pl1_posx;
            snap.pl1_posy      <= pl1_posy;
            snap.ball_posx     <= ball_posx;
            snap.ball_posy     <= ball_posy;
            slot               <= '0;
            word_if.word_valid <= 1'b1;
            busy               <= 1'b1;
            state              <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (word_if.word_valid && word_if.word_ready) begin
            if (slot == SLOT_LAST) begin
              word_if.word_valid <= 1'b0;
              slot               <= '0;
              if (MIN_GAP == 0) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= ST_GAP;
              end
            end else begin
              slot <= slot + 3'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          word_if.word_valid <= 1'b0;
          busy               <= 1'b0;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Scoreboard bench for uart_frame_sched: stimulus pushes expected words,
// a negedge monitor pops and compares every transferred word.
module tb_uart_frame_sched;
  import uart_proto_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game;
  logic        busy;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  uart_frame_sched_if wif();

  uart_frame_sched #(.MIN_GAP(16), .DROP_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .pl1_posx   (pl1_posx),
    .pl1_posy   (pl1_posy),
    .ball_posx  (ball_posx),
    .ball_posy  (ball_posy),
    .pl1_score  (pl1_score),
    .pl2_score  (pl2_score),
    .flag_point (flag_point),
    .end_game   (end_game),
    .word_if    (wif),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer is judged in the cycle it is offered; held words
  // must match the word still waiting at the head of the queue.
  always @(negedge clk) begin
    if (!rst && wif.word_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none", wif.word_data);
      end else if (wif.word_ready) begin
        chk("word", {16'h0, wif.word_data}, {16'h0, exp_q.pop_front()});
      end else begin
        chk("word_hold", {16'h0, wif.word_data}, {16'h0, exp_q[0]});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick;
    frame_tick = 1'b1;
    step;
    frame_tick = 1'b0;
  endtask

  task automatic set_vals;
    pl1_posx  = 12'h123;
    pl1_posy  = 12'h456;
    ball_posx = 12'h789;
    ball_posy = 12'hABC;
    pl1_score = 4'd2;
    pl2_score = 4'd5;
  endtask

  task automatic push_frame(input logic pt, input logic en);
    logic [11:0] ctrl;
    ctrl = {2'b00, en, pt, pl2_score, pl1_score};
    exp_q.push_back({4'h0, ctrl});
    exp_q.push_back({4'h3, pl1_posx});
    exp_q.push_back({4'h4, pl1_posy});
    exp_q.push_back({4'h5, ball_posx});
    exp_q.push_back({4'h6, ball_posy});
`ifdef UART_FRAME_CHECKSUM_EN
    exp_q.push_back({4'hF, ctrl ^ pl1_posx ^ pl1_posy ^ ball_posx ^ ball_posy});
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      step;
      n++;
    end
    chk(name, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_gap(input string name);
    int n = 0;
    while (!(busy && !wif.word_valid) && n < 100) begin
      step;
      n++;
    end
    chk(name, {30'h0, busy, wif.word_valid}, 32'h2);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; flag_point = 1'b0; end_game = 1'b0;
    wif.word_ready = 1'b1;
    set_vals;
    step; step;
    chk("rst_valid", {31'h0, wif.word_valid}, 32'h0);
    chk("rst_data", {16'h0, wif.word_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_drop", {24'h0, drop_cnt}, 32'h0);
    rst = 1'b0;
    step;

    // 1: single frame, back-to-back words, then MIN_GAP busy cycles
    push_frame(1'b0, 1'b0);
    pulse_tick;
    chk("t1_first_word", {16'h0, wif.word_data}, 32'h0052);
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", {31'h0, wif.word_valid}, 32'h1);
      step;
    end
    for (int i = 0; i < 16; i++) begin
      chk("t1_gap_busy", {31'h0, busy}, 32'h1);
      chk("t1_gap_novalid", {31'h0, wif.word_valid}, 32'h0);
      step;
    end
    chk("t1_idle", {31'h0, busy}, 32'h0);

    // 2: backpressure on slot 2 with inputs changing mid-frame
    push_frame(1'b0, 1'b0);
    pulse_tick;
    step; step;
    chk("t2_slot2", {16'h0, wif.word_data}, 32'h4456);
    wif.word_ready = 1'b0;
    pl1_posx = 12'hFFF; pl1_posy = 12'h001; ball_posx = 12'h333;
    ball_posy = 12'h444; pl1_score = 4'hF; pl2_score = 4'hE;
    step; step; step;
    wif.word_ready = 1'b1;
    wait_idle("t2_done");
    set_vals;

    // 3: point pulse in GAP lands in the next frame only; end_game on accept edge
    push_frame(1'b0, 1'b0);
    pulse_tick;
    wait_gap("t3_reach_gap");
    flag_point = 1'b1;
    step;
    flag_point = 1'b0;
    wait_idle("t3_done_a");
    push_frame(1'b1, 1'b0);
    pulse_tick;
    chk("t3_point_word", {16'h0, wif.word_data}, 32'h0152);
    wait_idle("t3_done_b");
    push_frame(1'b0, 1'b1);
    end_game = 1'b1;
    pulse_tick;
    end_game = 1'b0;
    chk("t3_end_word", {16'h0, wif.word_data}, 32'h0252);
    wait_idle("t3_done_c");
    push_frame(1'b0, 1'b0);
    pulse_tick;
    wait_idle("t3_done_d");

    // 4: drop counting and saturation while a frame is held in flight
    push_frame(1'b0, 1'b0);
    pulse_tick;
    wif.word_ready = 1'b0;
    frame_tick = 1'b1;
    for (int i = 0; i < 3; i++) step;
    frame_tick = 1'b0;
    chk("t4_drop3", {24'h0, drop_cnt}, 32'd3);
    frame_tick = 1'b1;
    for (int i = 0; i < 300; i++) step;
    frame_tick = 1'b0;
    chk("t4_drop_sat", {24'h0, drop_cnt}, 32'hFF);
    wif.word_ready = 1'b1;
    wait_gap("t4_reach_gap");
    pulse_tick;
    chk("t4_drop_sat_gap", {24'h0, drop_cnt}, 32'hFF);
    wait_idle("t4_done");

    // 5: reset after slot 1 transfers, then restart from slot 0
    exp_q.push_back(16'h0052);
    exp_q.push_back(16'h3123);
    pulse_tick;
    flag_point = 1'b1;
    step;
    flag_point = 1'b0;
    step;
    rst = 1'b1;
    wif.word_ready = 1'b0;
    step;
    chk("t5_rst_valid", {31'h0, wif.word_valid}, 32'h0);
    chk("t5_rst_drop", {24'h0, drop_cnt}, 32'h0);
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    wif.word_ready = 1'b1;
    step;
    push_frame(1'b0, 1'b0);
    pulse_tick;
    chk("t5_restart_slot0", {16'h0, wif.word_data}, 32'h0052);
    for (int i = 0; i < 4; i++) step;
    frame_tick = 1'b1;
    step;
    frame_tick = 1'b0;
    chk("t5_drop_last_xfer", {24'h0, drop_cnt}, 32'd1);
    for (int i = 0; i < 15; i++) step;
    frame_tick = 1'b1;
    step;
    frame_tick = 1'b0;
    chk("t5_drop_gap_expiry", {24'h0, drop_cnt}, 32'd2);
    chk("t5_idle_after_gap", {31'h0, busy}, 32'h0);
    push_frame(1'b0, 1'b0);
    pulse_tick;
    wait_idle("t5_done");

    step; step;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
